// File: rtl/memoria_datos_ext.sv
// Byte-addressed little-endian data memory with sized, sign/zero-extended loads and a debug dump FSM.
// Loads return one cycle after acceptance; accesses are ignored while a dump is in progress.
module memoria_datos_ext #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_ALUDireccion,
  input  logic [NBITS-1:0] i_DatoRegistro,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_Tamano,
  input  logic             i_Signo,
  output logic [NBITS-1:0] o_DatoLeido,
  output logic             o_Valido,
  output logic             o_Desalineado,
  input  logic             i_DebugDump,
  output logic [NBITS-1:0] o_DebugDato,
  output logic             o_DebugValido,
  output logic             o_DebugFin,
  output logic             o_DebugOcupado
);

  localparam int AW = $clog2(CELDAS);

  typedef logic [NBITS-1:0] mem_t [CELDAS];
  typedef enum logic [1:0] {IDLE, DUMP, FIN} estado_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < CELDAS; i++) m[i] = NBITS'(i + 1);
    return m;
  endfunction

  mem_t            mem_q = init_mem();
  estado_t         estado_q;
  logic [AW-1:0]   cnt_q;
  logic [NBITS-1:0] dato_q, debug_dato_q;
  logic            valido_q, desal_q, debug_valido_q, debug_fin_q, ocupado_q;

  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic             es_half, es_word, desal;
  logic [NBITS-1:0] palabra, lectura_d;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             unused_bits;

  // Address bits above the memory size are don't-care: accesses wrap.
  assign unused_bits = ^i_ALUDireccion[NBITS-1:AW+2];

  assign idx      = i_ALUDireccion[AW+1:2];
  assign lane     = i_ALUDireccion[1:0];
  assign es_half  = (i_Tamano == 2'b01);
  assign es_word  = i_Tamano[1];
  assign desal    = (es_half & lane[0]) | (es_word & (lane != 2'b00));
  assign palabra  = mem_q[idx];
  assign byte_sel = palabra[{lane, 3'b000} +: 8];
  assign half_sel = palabra[{lane[1], 4'b0000} +: 16];

  always_comb begin
    lectura_d = palabra;
    if (i_Tamano == 2'b00)
      lectura_d = {{(NBITS-8){i_Signo & byte_sel[7]}}, byte_sel};
    else if (es_half)
      lectura_d = {{(NBITS-16){i_Signo & half_sel[15]}}, half_sel};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      estado_q       <= IDLE;
      cnt_q          <= '0;
      dato_q         <= '0;
      valido_q       <= 1'b0;
      desal_q        <= 1'b0;
      debug_dato_q   <= '0;
      debug_valido_q <= 1'b0;
      debug_fin_q    <= 1'b0;
      ocupado_q      <= 1'b0;
    end else begin
      case (estado_q)
        IDLE: begin
          debug_valido_q <= 1'b0;
          debug_fin_q    <= 1'b0;
          if ((i_MemRead | i_MemWrite) & desal) begin
            dato_q   <= '0;
            valido_q <= 1'b0;
            desal_q  <= 1'b1;
          end else begin
            desal_q  <= 1'b0;
            valido_q <= i_MemRead;
            // Read uses the pre-write word, so same-cycle read/write is read-before-write.
            if (i_MemRead) dato_q <= lectura_d;
            if (i_MemWrite) begin
              if (i_Tamano == 2'b00)
                mem_q[idx][{lane, 3'b000} +: 8] <= i_DatoRegistro[7:0];
              else if (es_half)
                mem_q[idx][{lane[1], 4'b0000} +: 16] <= i_DatoRegistro[15:0];
              else
                mem_q[idx] <= i_DatoRegistro;
            end
          end
          if (i_DebugDump) begin
            estado_q  <= DUMP;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
          end
        end
        DUMP: begin
          valido_q       <= 1'b0;
          desal_q        <= 1'b0;
          debug_dato_q   <= mem_q[cnt_q];
          debug_valido_q <= 1'b1;
          cnt_q          <= cnt_q + AW'(1);
          if (cnt_q == AW'(CELDAS - 1)) estado_q <= FIN;
        end
        FIN: begin
          debug_valido_q <= 1'b0;
          debug_fin_q    <= 1'b1;
          ocupado_q      <= 1'b0;
          estado_q       <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign o_DatoLeido    = dato_q;
  assign o_Valido       = valido_q;
  assign o_Desalineado  = desal_q;
  assign o_DebugDato    = debug_dato_q;
  assign o_DebugValido  = debug_valido_q;
  assign o_DebugFin     = debug_fin_q;
  assign o_DebugOcupado = ocupado_q;

endmodule

// File: tb/tb_memoria_datos_ext.sv
// Scoreboard bench for memoria_datos_ext: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_memoria_datos_ext;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_ALUDireccion = '0, i_DatoRegistro = '0;
  logic        i_MemWrite = 1'b0, i_MemRead = 1'b0;
  logic [1:0]  i_Tamano = 2'b11;
  logic        i_Signo = 1'b0, i_DebugDump = 1'b0;
  logic [31:0] o_DatoLeido, o_DebugDato;
  logic        o_Valido, o_Desalineado, o_DebugValido, o_DebugFin, o_DebugOcupado;

  int total = 0;
  int bad = 0;
  int fin_seen = 0;
  int dump_seen = 0;
  logic [32:0] lq[$];
  logic [31:0] dq[$];

  always #5 clk = ~clk;

  memoria_datos_ext #(.NBITS(32), .CELDAS(64)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ALUDireccion(i_ALUDireccion),
    .i_DatoRegistro(i_DatoRegistro), .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead),
    .i_Tamano(i_Tamano), .i_Signo(i_Signo), .o_DatoLeido(o_DatoLeido),
    .o_Valido(o_Valido), .o_Desalineado(o_Desalineado), .i_DebugDump(i_DebugDump),
    .o_DebugDato(o_DebugDato), .o_DebugValido(o_DebugValido), .o_DebugFin(o_DebugFin),
    .o_DebugOcupado(o_DebugOcupado)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: load responses and dump words are compared against the queues.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_Valido || o_Desalineado) begin
        if (lq.size() == 0) chk("unexpected_load_resp", {o_Valido, o_Desalineado}, 0);
        else begin
          logic [32:0] e;
          e = lq.pop_front();
          chk("load_mis", {31'd0, o_Desalineado}, {31'd0, e[32]});
          chk("load_vld", {31'd0, o_Valido}, {31'd0, ~e[32]});
          chk("load_data", o_DatoLeido, e[31:0]);
        end
      end
      if (o_DebugValido) begin
        dump_seen++;
        if (dq.size() == 0) chk("unexpected_dump_word", o_DebugDato, 32'hx);
        else chk("dump_word", o_DebugDato, dq.pop_front());
      end
      if (o_DebugFin) fin_seen++;
    end
  end

  task automatic acc(input logic rd, input logic wr, input logic [1:0] t, input logic s,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic ex, input logic mis, input logic [31:0] ed);
    @(negedge clk);
    i_MemRead = rd; i_MemWrite = wr; i_Tamano = t; i_Signo = s;
    i_ALUDireccion = a; i_DatoRegistro = d;
    if (ex) lq.push_back({mis, ed});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_MemRead = 0; i_MemWrite = 0; i_DebugDump = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_dump();
    for (int i = 0; i < 64; i++) begin
      case (i)
        1:       dq.push_back(32'h0000_8002);
        2:       dq.push_back(32'h1234_0003);
        3:       dq.push_back(32'hDEAD_BEEF);
        default: dq.push_back(32'(i + 1));
      endcase
    end
  endtask

  task automatic start_dump();
    @(negedge clk);
    i_DebugDump = 1;
    @(negedge clk);
    i_DebugDump = 0;
  endtask

  task automatic wait_fin(input int prev);
    int n = 0;
    while (fin_seen == prev && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("dump_fin_timeout", {31'd0, n < 200}, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dato"}, o_DatoLeido, 0);
    chk({tag, "_flags"}, {26'd0, o_Valido, o_Desalineado, o_DebugValido, o_DebugFin, o_DebugOcupado, 1'b0}, 0);
    chk({tag, "_ddato"}, o_DebugDato, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 chk_zero("reset");
    @(negedge clk) i_reset = 0;

    acc(1, 0, 2'b11, 0, 32'h08, 0, 1, 0, 32'h0000_0003);
    acc(0, 1, 2'b00, 0, 32'h05, 32'h0000_0080, 0, 0, 0);
    acc(1, 0, 2'b00, 1, 32'h05, 0, 1, 0, 32'hFFFF_FF80);
    acc(1, 0, 2'b00, 0, 32'h05, 0, 1, 0, 32'h0000_0080);
    acc(1, 0, 2'b11, 0, 32'h04, 0, 1, 0, 32'h0000_8002);
    acc(0, 1, 2'b01, 0, 32'h0A, 32'h0000_1234, 0, 0, 0);
    acc(1, 0, 2'b11, 0, 32'h08, 0, 1, 0, 32'h1234_0003);
    acc(1, 0, 2'b01, 1, 32'h0B, 0, 1, 1, 32'h0);
    acc(0, 1, 2'b11, 0, 32'h09, 32'hFFFF_FFFF, 1, 1, 32'h0);
    acc(0, 1, 2'b10, 0, 32'h0E, 32'hFFFF_FFFF, 1, 1, 32'h0);
    acc(1, 0, 2'b11, 0, 32'h08, 0, 1, 0, 32'h1234_0003);
    acc(1, 1, 2'b11, 0, 32'h0C, 32'hDEAD_BEEF, 1, 0, 32'h0000_0004);
    acc(1, 0, 2'b11, 0, 32'h0C, 0, 1, 0, 32'hDEAD_BEEF);
    acc(1, 0, 2'b10, 0, 32'h10, 0, 1, 0, 32'h0000_0005);
    acc(1, 0, 2'b01, 0, 32'h0E, 0, 1, 0, 32'h0000_DEAD);
    acc(1, 0, 2'b01, 1, 32'h0E, 0, 1, 0, 32'hFFFF_DEAD);
    acc(1, 0, 2'b00, 1, 32'h0F, 0, 1, 0, 32'hFFFF_FFDE);
    acc(1, 0, 2'b01, 1, 32'h0A, 0, 1, 0, 32'h0000_1234);
    acc(1, 0, 2'b11, 0, 32'h108, 0, 1, 0, 32'h1234_0003);
    idle(1);
    chk("hold_dato", o_DatoLeido, 32'h1234_0003);

    // Full dump; store and load issued mid-dump must be ignored.
    push_dump();
    start_dump();
    @(posedge clk); #2;
    chk("busy_in_dump", {31'd0, o_DebugOcupado}, 1);
    acc(1, 1, 2'b11, 0, 32'h20, 32'h0000_0055, 0, 0, 0);
    idle(0);
    wait_fin(0);
    @(posedge clk); #2;
    chk("busy_after_fin", {31'd0, o_DebugOcupado}, 0);
    chk("dump_all_words", dq.size(), 0);
    acc(1, 0, 2'b11, 0, 32'h20, 0, 1, 0, 32'h0000_0009);
    idle(1);

    // Reset in the middle of a dump.
    dump_seen = 0;
    push_dump();
    start_dump();
    for (int n = 0; n < 200 && dump_seen < 10; n++) begin
      @(posedge clk); #2;
    end
    chk("dump_reach_10", dump_seen, 10);
    i_reset = 1;
    @(posedge clk); #2;
    chk_zero("mid_dump_reset");
    dq.delete();
    i_reset = 0;
    idle(1);
    chk("no_dump_after_reset", {31'd0, o_DebugValido}, 0);

    push_dump();
    start_dump();
    wait_fin(1);
    chk("redump_all_words", dq.size(), 0);
    idle(2);
    chk("load_queue_drained", lq.size(), 0);
    chk("fin_count", fin_seen, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memoria_datos_ext.md
MEMORIA_DATOS_EXT -- requirements
Module: memoria_datos_ext

Interface
REQ-001 SHALL have parameter NBITS, default 32, data word width in bits.
REQ-002 SHALL have parameter CELDAS, default 64, depth in words (power of 2); AW = clog2(CELDAS).
REQ-003 SHALL have ports:
- i_clk  in  1  single clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_ALUDireccion  in  NBITS  byte address.
- i_DatoRegistro  in  NBITS  store data, right-aligned.
- i_MemWrite  in  1  store request.
- i_MemRead  in  1  load request.
- i_Tamano  in  2  access size: 00 byte, 01 half, 11 word, 10 reserved.
- i_Signo  in  1  1 = sign-extend loads, 0 = zero-extend.
- o_DatoLeido  out  NBITS  registered load data.
- o_Valido  out  1  load-data-valid pulse.
- o_Desalineado  out  1  misaligned-access pulse.
- i_DebugDump  in  1  start a full-memory dump.
- o_DebugDato  out  NBITS  dumped word.
- o_DebugValido  out  1  o_DebugDato valid.
- o_DebugFin  out  1  dump-complete pulse.
- o_DebugOcupado  out  1  dump in progress.

Function
REQ-004 SHALL use byte addressing, little-endian: word index = i_ALUDireccion[AW+1:2], lane = [1:0]; upper address bits ignored (wrap modulo 4*CELDAS bytes).
REQ-005 SHALL treat i_Tamano=10 as word.
REQ-006 SHALL define misaligned as: half with addr[0]=1, or word with addr[1:0]!=00.
REQ-007 SHALL, on posedge with i_MemWrite=1, aligned, and FSM in IDLE, write only the addressed lanes: byte writes i_DatoRegistro[7:0], half writes [15:0]; other lanes unchanged.
REQ-008 SHALL, on posedge with i_MemRead=1, aligned, FSM in IDLE, register the extracted lane(s), extended per i_Signo, into o_DatoLeido and assert o_Valido for exactly one cycle (latency 1).
REQ-009 SHALL hold o_DatoLeido at its last value when no load is accepted; o_Valido=0.
REQ-010 SHALL, on simultaneous read and write to the same word, return pre-write data (read-before-write) and perform the write.
REQ-011 SHALL, on a misaligned access, suppress the write, set o_DatoLeido=0, o_Valido=0, and pulse o_Desalineado for one cycle.
REQ-012 SHALL implement dump FSM states IDLE, DUMP, FIN.
REQ-013 SHALL transition IDLE->DUMP when i_DebugDump=1, with word counter cleared to 0.
REQ-014 SHALL, in DUMP, present memory[counter] on o_DebugDato with o_DebugValido=1 each cycle, incrementing the counter; after counter=CELDAS-1, go to FIN (exactly CELDAS valid cycles).
REQ-015 SHALL, in FIN, pulse o_DebugFin for one cycle, then return to IDLE.
REQ-016 SHALL assert o_DebugOcupado in DUMP and FIN; while asserted, loads and stores are ignored (no write, o_Valido=0, o_Desalineado=0); i_DebugDump is ignored outside IDLE.
REQ-017 SHALL initialise memory at configuration to cell[i] = i+1.

Reset
REQ-018 SHALL, on i_reset=1 at posedge, clear o_DatoLeido, o_Valido, o_Desalineado, o_DebugDato, o_DebugValido, o_DebugFin, o_DebugOcupado and the counter, and enter IDLE, including mid-dump.
REQ-019 SHALL NOT alter memory contents on reset; reset takes priority over all accesses in that cycle.

Verification
REQ-020 Post-config LW addr 0x08 -> next cycle o_DatoLeido=0x00000003, o_Valido=1 for one cycle.
REQ-021 SB 0x80 to addr 0x05, then LB signed 0x05 -> 0xFFFFFF80; LBU 0x05 -> 0x00000080; LW 0x04 -> 0x00008002.
REQ-022 SH addr 0x0A data 0x1234, then LW 0x08 -> 0x12340003; LH addr 0x0B -> o_Desalineado pulse, o_DatoLeido=0, memory unchanged.
REQ-023 Simultaneous SW 0xDEADBEEF and LW at 0x0C -> read returns 0x00000004; later LW 0x0C -> 0xDEADBEEF.
REQ-024 i_DebugDump pulse -> CELDAS consecutive o_DebugValido cycles with words 1..CELDAS, then one-cycle o_DebugFin; SW issued during dump has no effect.
REQ-025 i_reset asserted at dump word 10 -> next cycle all outputs 0, FSM IDLE, memory intact; new dump restarts at word 0.
